// File: rtl/chess_pkg.sv
// chess_pkg: shared widths, move type and scheduler state encoding
package chess_pkg;
    localparam int MOVE_W  = 12;
    localparam int SCORE_W = 16;
    typedef logic [MOVE_W-1:0] move_t;
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} sched_state_t;
endpackage

// File: rtl/minimax_move_scheduler_move_buffer.sv
// move_buffer: candidate move register file with write pointer and read index
module move_buffer
    import chess_pkg::*;
#(
    parameter int DEPTH = 10
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  wr_en,
    input  move_t wr_data,
    input  logic  rd_next,
    output logic  full,
    output logic  last,
    output move_t rd_data
);
    localparam int CW = $clog2(DEPTH + 1);
    move_t mem [DEPTH];
    logic [CW-1:0] count, idx;
    assign full    = count == CW'(DEPTH);
    assign last    = idx + CW'(1) == count;
    assign rd_data = mem[idx];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            idx   <= '0;
        end else if (clr) begin
            count <= '0;
            idx   <= '0;
        end else begin
            if (wr_en && !full) count <= count + CW'(1);
            if (rd_next) idx <= idx + CW'(1);
        end
    end
    // storage needs no reset: entries are only read below the write pointer
    always_ff @(posedge clk) begin
        if (wr_en && !full && !clr) mem[count] <= wr_data;
    end
endmodule

// File: rtl/minimax_move_scheduler.sv
// minimax_move_scheduler: buffers streamed moves, evaluates each in turn, reports the best
module minimax_move_scheduler
    import chess_pkg::*;
#(
    parameter int MAX_MOVES = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      white_to_move,
    input  logic                      mv_valid,
    input  logic [MOVE_W-1:0]         mv_data,
    input  logic                      mv_last,
    input  logic                      mv_empty,
    output logic                      mv_ready,
    output logic                      eval_req,
    output logic [MOVE_W-1:0]         eval_move,
    input  logic                      eval_ack,
    input  logic signed [SCORE_W-1:0] eval_score,
    output logic                      busy,
    output logic                      done,
    output logic [MOVE_W-1:0]         next_move,
    output logic                      no_move,
    output logic                      overflow
);
    sched_state_t state, state_nx;
    logic wtm, best_valid, go, beat, ack, take, full, last;
    logic signed [SCORE_W-1:0] best_score;
    move_t best_move, rd_data;
    assign go        = start && (state == IDLE || state == DONE);
    assign beat      = state == LOAD && mv_valid;
    assign ack       = state == WAIT && eval_ack;
    assign take      = !best_valid || (wtm ? eval_score > best_score : eval_score < best_score);
    assign mv_ready  = state == LOAD;
    assign eval_req  = state == WAIT;
    assign eval_move = eval_req ? rd_data : '0;
    assign busy      = state == LOAD || state == ISSUE || state == WAIT;
    move_buffer #(.DEPTH(MAX_MOVES)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (go),
        .wr_en   (beat),
        .wr_data (mv_data),
        .rd_next (ack && !last),
        .full    (full),
        .last    (last),
        .rd_data (rd_data)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? LOAD : IDLE;
            LOAD:    state_nx = beat && mv_last ? ISSUE : mv_empty ? DONE : LOAD;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = eval_ack ? (last ? DONE : ISSUE) : WAIT;
            DONE:    state_nx = go ? LOAD : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wtm        <= 1'b0;
            best_valid <= 1'b0;
            best_score <= '0;
            best_move  <= '0;
            done       <= 1'b0;
            next_move  <= '0;
            no_move    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= state != DONE && state_nx == DONE;
            if (go) begin
                wtm        <= white_to_move;
                best_valid <= 1'b0;
                overflow   <= 1'b0;
                no_move    <= 1'b0;
            end
            if (beat && full) overflow <= 1'b1;
            if (ack && take) begin
                best_valid <= 1'b1;
                best_score <= eval_score;
                best_move  <= rd_data;
            end
            if (state == LOAD && state_nx == DONE) begin
                no_move   <= 1'b1;
                next_move <= '0;
            end
            // the final ack must be folded in before it lands in best_move
            if (ack && last) next_move <= take ? rd_data : best_move;
        end
    end
endmodule

// File: tb/tb_minimax_move_scheduler.sv
// tb_minimax_move_scheduler: table-driven directed searches with a random-latency evaluator
module tb_minimax_move_scheduler;
    logic clk = 0, rst_n = 0, start = 0, white_to_move = 0;
    logic mv_valid = 0, mv_last = 0, mv_empty = 0, eval_ack = 0;
    logic [11:0] mv_data = 0;
    logic signed [15:0] eval_score = 0;
    logic mv_ready, eval_req, busy, done, no_move, overflow;
    logic [11:0] eval_move, next_move;

    minimax_move_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .white_to_move(white_to_move),
        .mv_valid(mv_valid), .mv_data(mv_data), .mv_last(mv_last), .mv_empty(mv_empty),
        .mv_ready(mv_ready), .eval_req(eval_req), .eval_move(eval_move), .eval_ack(eval_ack),
        .eval_score(eval_score), .busy(busy), .done(done), .next_move(next_move),
        .no_move(no_move), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        white;
        int          n;
        logic [11:0] base;
        int          sc [12];
        logic [11:0] exp_move;
        logic        exp_no_move;
        logic        exp_ovf;
        int          exp_reqs;
        logic        busy_start;
    } vec_t;

    vec_t vecs [10];
    vec_t cur;
    int tests = 0, fails = 0;
    int reqs, bad_seen, stable_err;
    logic ev_active;
    int ev_delay;
    logic [11:0] ev_move;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int k, input logic w, input int n, input logic [11:0] base,
                       input int s [12], input int best_i, input logic bs);
        vecs[k].white       = w;
        vecs[k].n           = n;
        vecs[k].base        = base;
        vecs[k].sc          = s;
        vecs[k].exp_move    = n == 0 ? 12'h0 : base + 12'(best_i + 1);
        vecs[k].exp_no_move = n == 0;
        vecs[k].exp_ovf     = n > 10;
        vecs[k].exp_reqs    = n > 10 ? 10 : n;
        vecs[k].busy_start  = bs;
    endtask

    function automatic int lookup(input logic [11:0] m);
        for (int i = 0; i < cur.n; i++)
            if (cur.base + 12'(i + 1) == m) begin
                if (i >= 10) bad_seen++;
                return cur.sc[i];
            end
        bad_seen++;
        return 0;
    endfunction

    initial begin : evaluator
        ev_active = 0;
        forever begin
            @(negedge clk);
            eval_ack = 0;
            if (!rst_n) ev_active = 0;
            else if (eval_req) begin
                if (!ev_active) begin
                    ev_active = 1;
                    ev_delay  = $urandom_range(0, 5);
                    ev_move   = eval_move;
                    reqs++;
                end else if (eval_move !== ev_move) stable_err++;
                if (ev_delay == 0) begin
                    eval_ack   = 1;
                    eval_score = 16'(lookup(eval_move));
                    ev_active  = 0;
                end else ev_delay--;
            end
        end
    end

    task automatic stream(input vec_t v);
        int t;
        cur = v; reqs = 0; bad_seen = 0; stable_err = 0;
        @(negedge clk);
        white_to_move = v.white; start = 1;
        @(negedge clk);
        start = 0;
        if (v.n == 0) begin
            mv_empty = 1;
            @(negedge clk);
            mv_empty = 0;
        end
        for (int i = 0; i < v.n; i++) begin
            mv_valid = 1; mv_data = v.base + 12'(i + 1); mv_last = i == v.n - 1;
            t = 0;
            while (!mv_ready && t < 20) begin @(negedge clk); t++; end
            @(negedge clk);
        end
        mv_valid = 0; mv_last = 0;
    endtask

    task automatic finish_vec(input int k, input vec_t v);
        int t = 0;
        string s;
        s = $sformatf("v%0d", k);
        if (v.busy_start) begin
            chk({s, "_busy"}, 32'(busy), 1);
            white_to_move = ~v.white; start = 1;
            @(negedge clk);
            start = 0;
        end
        while (!done && t < 300) begin @(negedge clk); t++; end
        chk({s, "_done"}, 32'(done), 1);
        if (v.n == 0) chk({s, "_empty_latency"}, 32'(t), 0);
        chk({s, "_next_move"}, 32'(next_move), 32'(v.exp_move));
        chk({s, "_no_move"}, 32'(no_move), 32'(v.exp_no_move));
        chk({s, "_overflow"}, 32'(overflow), 32'(v.exp_ovf));
        chk({s, "_reqs"}, 32'(reqs), 32'(v.exp_reqs));
        chk({s, "_bad_moves"}, 32'(bad_seen), 0);
        chk({s, "_stable"}, 32'(stable_err), 0);
        chk({s, "_idle_busy"}, 32'(busy), 0);
        @(negedge clk);
        chk({s, "_done_pulse"}, 32'(done), 0);
        chk({s, "_held"}, 32'(next_move), 32'(v.exp_move));
    endtask

    initial begin : main
        int t;
        add(0, 1, 3, 12'h100, '{5, -2, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 2, 0);
        add(1, 0, 3, 12'h100, '{5, -2, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 0);
        add(2, 1, 2, 12'h110, '{4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 0);
        add(3, 0, 2, 12'h110, '{4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 0);
        add(4, 1, 0, 12'h000, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 0);
        add(5, 1, 12, 12'h400, '{3, -7, 12, 0, 12, -1, 8, 2, 11, 5, 100, 200}, 2, 0);
        add(6, 0, 12, 12'h400, '{3, -7, 12, 0, 12, -1, 8, 2, 11, 5, -100, -200}, 1, 0);
        add(7, 0, 1, 12'h0A0, '{-300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 0);
        add(8, 1, 3, 12'h510, '{-5, 3, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 0);
        add(9, 1, 3, 12'h100, '{5, -2, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 2, 1);
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(mv_ready), 0);
        chk("rst_req", 32'(eval_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {29'b0, done, no_move, overflow}, 0);
        chk("rst_next_move", 32'(next_move), 0);
        rst_n = 1;
        for (int k = 0; k < 10; k++) begin
            stream(vecs[k]);
            finish_vec(k, vecs[k]);
        end
        stream(vecs[5]);
        t = 0;
        while (!eval_req && t < 50) begin @(negedge clk); t++; end
        chk("mid_wait_req", 32'(eval_req), 1);
        #2 rst_n = 0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_req", 32'(eval_req), 0);
        chk("async_ready", 32'(mv_ready), 0);
        chk("async_flags", {29'b0, done, no_move, overflow}, 0);
        chk("async_next_move", 32'(next_move), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        stream(vecs[0]);
        finish_vec(10, vecs[0]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
